// File: rtl/ram4k_loader.sv
// rtl/ram4k_loader.sv - boot-time byte-stream image loader in front of a 4K-word RAM
//
// Packs a high-byte-first byte stream into 16-bit words and writes them to
// consecutive RAM addresses starting at 0. It keeps a running word count and a
// mod-2^16 checksum of the words written. When no load is active, the CPU write
// port passes straight through to the RAM.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               begin a load / cancel a load in progress (abort wins)
//   byte_valid, byte_data      incoming byte stream
//   byte_ready                 loader accepts a byte this cycle
//   cpu_in, cpu_load,
//   cpu_address                CPU write request (passed through while idle)
//   ram_in, ram_load,
//   ram_address                RAM write port
//   busy, done                 load in progress / last load completed in full
//   word_count, checksum       progress and running sum of the current or last load
module ram4k_loader #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [15:0] cpu_in,
    input  logic        cpu_load,
    input  logic [11:0] cpu_address,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [11:0] ram_address,
    output logic        busy,
    output logic        done,
    output logic [12:0] word_count,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [12:0] LAST_IDX = 13'(WORDS - 1);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [11:0] addr_q, addr_d;
    logic [12:0] word_count_q, word_count_d;
    logic [15:0] checksum_q, checksum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_q       <= 16'h0000;
            addr_q       <= 12'h000;
            word_count_q <= 13'h0000;
            checksum_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        byte_ready   = 1'b0;
        busy         = 1'b0;
        ram_in       = cpu_in;
        ram_load     = cpu_load;
        ram_address  = cpu_address;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d      = S_HI;
                    addr_d       = 12'h000;
                    word_count_d = 13'h0000;
                    checksum_d   = 16'h0000;
                end
            end
            S_HI, S_LO: begin
                // The loader owns the RAM port for the whole load, so CPU
                // writes are dropped rather than slipped in between words.
                busy        = 1'b1;
                byte_ready  = 1'b1;
                ram_in      = hold_q;
                ram_address = addr_q;
                ram_load    = 1'b0;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (byte_valid) begin
                    if (state_q == S_HI) begin
                        hold_d[15:8] = byte_data;
                        state_d      = S_LO;
                    end else begin
                        hold_d[7:0] = byte_data;
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                busy        = 1'b1;
                ram_in      = hold_q;
                ram_address = addr_q;
                // An abort landing on the write cycle suppresses the write.
                ram_load    = !abort;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // With WORDS = 4096 the address wraps to 0 on the final
                    // write, but the FSM leaves for DONE on that same edge.
                    addr_d       = addr_q + 12'd1;
                    word_count_d = word_count_q + 13'd1;
                    checksum_d   = checksum_q + hold_q;
                    state_d      = (word_count_q == LAST_IDX) ? S_DONE : S_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // DONE is only left on a new start, so done holds until then.
    assign done       = (state_q == S_DONE);
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_ram4k_loader.sv
// tb/tb_ram4k_loader.sv - self-checking testbench for ram4k_loader
module tb_ram4k_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [15:0] cpu_in = 16'h0000;
    logic        cpu_load = 1'b0;
    logic [11:0] cpu_address = 12'h000;

    always #5 clk = ~clk;

    // dut a: WORDS=3, dut b: WORDS=4, dut c: WORDS=4096 (shared stimulus)
    logic        a_byte_ready, a_ram_load, a_busy, a_done;
    logic [15:0] a_ram_in, a_checksum;
    logic [11:0] a_ram_address;
    logic [12:0] a_word_count;
    logic        b_byte_ready, b_ram_load, b_busy, b_done;
    logic [15:0] b_ram_in, b_checksum;
    logic [11:0] b_ram_address;
    logic [12:0] b_word_count;
    logic        c_byte_ready, c_ram_load, c_busy, c_done;
    logic [15:0] c_ram_in, c_checksum;
    logic [11:0] c_ram_address;
    logic [12:0] c_word_count;

    ram4k_loader #(.WORDS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_byte_ready),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
        .ram_in(a_ram_in), .ram_load(a_ram_load), .ram_address(a_ram_address),
        .busy(a_busy), .done(a_done), .word_count(a_word_count), .checksum(a_checksum)
    );

    ram4k_loader #(.WORDS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_byte_ready),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
        .ram_in(b_ram_in), .ram_load(b_ram_load), .ram_address(b_ram_address),
        .busy(b_busy), .done(b_done), .word_count(b_word_count), .checksum(b_checksum)
    );

    ram4k_loader #(.WORDS(4096)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(c_byte_ready),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_address(cpu_address),
        .ram_in(c_ram_in), .ram_load(c_ram_load), .ram_address(c_ram_address),
        .busy(c_busy), .done(c_done), .word_count(c_word_count), .checksum(c_checksum)
    );

    // RAM models / write monitors
    logic [15:0] mem_a [4096];
    int          a_wr_cnt = 0;
    int          b_wr_addr1 = 0;
    int          c_wr_cnt = 0;
    logic [11:0] c_last_addr = 12'h000;

    always @(posedge clk) begin
        if (a_ram_load) begin
            mem_a[a_ram_address] <= a_ram_in;
            a_wr_cnt <= a_wr_cnt + 1;
        end
        if (b_ram_load && b_ram_address == 12'h001) b_wr_addr1 <= b_wr_addr1 + 1;
        if (c_ram_load) begin
            c_wr_cnt    <= c_wr_cnt + 1;
            c_last_addr <= c_ram_address;
        end
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] bytes_q [$];

    typedef struct packed {
        logic [47:0] bytes;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] cs;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cur_ready(input int sel);
        case (sel)
            0: return a_byte_ready;
            1: return b_byte_ready;
            default: return c_byte_ready;
        endcase
    endfunction

    function automatic logic cur_done(input int sel);
        case (sel)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0; cpu_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start across one rising edge; returns at the following falling edge.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams bytes_q into the selected loader until done; cycles counts the
    // rising edges after the start edge up to and including the done edge.
    task automatic run_load(input int sel, input int stall_idx, input int stall_len,
                            input int start_at, output int cycles);
        int idx = 0;
        int stalled = 0;
        cycles = 0;
        while (!cur_done(sel) && cycles < 20000) begin
            start = (start_at > 0 && cycles == start_at);
            if (cur_ready(sel) && idx < bytes_q.size()) begin
                if (idx == stall_idx && stalled < stall_len) begin
                    byte_valid = 1'b0;
                    stalled++;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = bytes_q[idx];
                    idx++;
                end
            end else begin
                byte_valid = 1'b0;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (cycles >= 20000) begin
            tests++;
            fails++;
            $display("FAIL load_timeout: got %0d cycles without done, limit 20000", cycles);
        end
    endtask

    initial begin
        int cyc;
        int wr0;
        vecs[0] = '{48'h1234ABCD0001, 16'h1234, 16'hABCD, 16'h0001, 16'hBE02};
        vecs[1] = '{48'hFFFFFFFF0002, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000};
        vecs[2] = '{48'h800080001234, 16'h8000, 16'h8000, 16'h1234, 16'h1234};
        vecs[3] = '{48'h000000000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        // reset state and passthrough
        cpu_address = 12'h3C5;
        cpu_in = 16'h9876;
        #12;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_byte_ready", a_byte_ready, 0);
        check("rst_word_count", a_word_count, 0);
        check("rst_checksum", a_checksum, 0);
        check("rst_ram_address", a_ram_address, 12'h3C5);
        check("rst_ram_in", a_ram_in, 16'h9876);
        reset_all();

        // table-driven 3-word loads, no gaps
        for (int v = 0; v < 4; v++) begin
            reset_all();
            bytes_q.delete();
            for (int i = 0; i < 6; i++) bytes_q.push_back(vecs[v].bytes[47 - 8*i -: 8]);
            wr0 = a_wr_cnt;
            do_start();
            run_load(0, -1, 0, 0, cyc);
            check($sformatf("v%0d_cycles", v), cyc, 9);
            check($sformatf("v%0d_ram0", v), mem_a[0], vecs[v].w0);
            check($sformatf("v%0d_ram1", v), mem_a[1], vecs[v].w1);
            check($sformatf("v%0d_ram2", v), mem_a[2], vecs[v].w2);
            check($sformatf("v%0d_writes", v), a_wr_cnt - wr0, 3);
            check($sformatf("v%0d_word_count", v), a_word_count, 3);
            check($sformatf("v%0d_checksum", v), a_checksum, vecs[v].cs);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done_held", v), a_done, 1);
            check($sformatf("v%0d_busy", v), a_busy, 0);
        end

        // 5-cycle stall between high and low byte of word 0
        reset_all();
        bytes_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        wr0 = a_wr_cnt;
        do_start();
        run_load(0, 1, 5, 0, cyc);
        check("stall_cycles", cyc, 14);
        check("stall_writes", a_wr_cnt - wr0, 3);
        check("stall_ram0", mem_a[0], 16'h1234);
        check("stall_checksum", a_checksum, 16'hBE02);

        // CPU passthrough in IDLE, dropped during HI
        reset_all();
        cpu_address = 12'h123;
        cpu_in = 16'h5555;
        cpu_load = 1'b1;
        @(negedge clk);
        cpu_load = 1'b0;
        check("cpu_idle_write", mem_a[12'h123], 16'h5555);
        do_start();
        cpu_in = 16'hAAAA;
        cpu_load = 1'b1;
        #1;
        check("cpu_hi_ram_load", a_ram_load, 0);
        @(negedge clk);
        cpu_load = 1'b0;
        check("cpu_hi_dropped", mem_a[12'h123], 16'h5555);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("cpu_abort_idle", a_busy, 0);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", a_busy, 0);

        // reset pulsed in LO, then a fresh load from address 0
        reset_all();
        do_start();
        byte_valid = 1'b1; byte_data = 8'h77;
        @(negedge clk);
        byte_valid = 1'b0;
        check("rstlo_pre_busy", a_busy, 1);
        cpu_address = 12'h0AB;
        rst_n = 1'b0;
        #1;
        check("rstlo_busy", a_busy, 0);
        check("rstlo_byte_ready", a_byte_ready, 0);
        check("rstlo_ram_load", a_ram_load, 0);
        check("rstlo_ram_address", a_ram_address, 12'h0AB);
        @(negedge clk);
        rst_n = 1'b1;
        bytes_q = '{8'h5A, 8'h5A, 8'h11, 8'h11, 8'h22, 8'h22};
        do_start();
        run_load(0, -1, 0, 0, cyc);
        check("rstlo_ram0", mem_a[0], 16'h5A5A);
        check("rstlo_ram2", mem_a[2], 16'h2222);
        check("rstlo_checksum", a_checksum, 16'h8D8D);

        // abort in the WRITE cycle of word 2 (WORDS=4)
        reset_all();
        bytes_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wr0 = b_wr_addr1;
        do_start();
        begin
            int idx = 0;
            int n = 0;
            while (!(b_word_count == 13'd1 && b_ram_load) && n < 50) begin
                if (b_byte_ready && idx < bytes_q.size()) begin
                    byte_valid = 1'b1;
                    byte_data = bytes_q[idx];
                    idx++;
                end else begin
                    byte_valid = 1'b0;
                end
                @(negedge clk);
                n++;
            end
            byte_valid = 1'b0;
            check("abort_reached_write", n < 50, 1);
        end
        abort = 1'b1;
        #1;
        check("abort_ram_load", b_ram_load, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", b_busy, 0);
        check("abort_done", b_done, 0);
        check("abort_word_count", b_word_count, 1);
        check("abort_checksum", b_checksum, 16'hA1B2);
        check("abort_no_write_addr1", b_wr_addr1 - wr0, 0);

        // full 4096-word all-zero load with a start pulse mid-load
        reset_all();
        bytes_q.delete();
        for (int i = 0; i < 8192; i++) bytes_q.push_back(8'h00);
        wr0 = c_wr_cnt;
        do_start();
        run_load(2, -1, 0, 100, cyc);
        check("full_cycles", cyc, 12288);
        check("full_word_count", c_word_count, 4096);
        check("full_done", c_done, 1);
        check("full_last_addr", c_last_addr, 12'hFFF);
        check("full_writes", c_wr_cnt - wr0, 4096);
        check("full_checksum", c_checksum, 0);
        repeat (5) @(negedge clk);
        check("full_no_extra_write", c_wr_cnt - wr0, 4096);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram4k_loader.md
# ram4k_loader

Boot-time image loader that sits directly upstream of the 4K-word RAM.
- Takes a byte stream (high byte first) from the host download path, packs it into 16-bit words and writes them sequentially from address 0.
- While idle, passes CPU-side write requests straight through to the RAM.
- Reports progress, completion and a running 16-bit checksum of the words written.

## Interface
Parameters:
- WORDS, 4096, number of words per load, legal range 1..4096

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- abort  in  1  cancel a load in progress; wins over start
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte, high byte of each word first
- byte_ready  out  1  loader accepts a byte this cycle
- cpu_in  in  16  CPU write data (idle passthrough)
- cpu_load  in  1  CPU write enable (idle passthrough)
- cpu_address  in  12  CPU address (idle passthrough)
- ram_in  out  16  RAM data input
- ram_load  out  1  RAM write enable
- ram_address  out  12  RAM address
- busy  out  1  load in progress (HI, LO or WRITE)
- done  out  1  last load completed in full; held until the next start
- word_count  out  13  words written in the current or last load
- checksum  out  16  mod-2^16 sum of words written in the current or last load

## Operation
States: IDLE, HI, LO, WRITE, DONE.
- IDLE/DONE:
  - ram_in = cpu_in, ram_load = cpu_load, ram_address = cpu_address (combinational).
  - byte_ready = 0.
  - start = 1 and abort = 0:
    - clear word_count, checksum and the address counter;
    - clear done;
    - go to HI.
- HI:
  - byte_ready = 1.
  - On byte_valid: latch byte_data into hold[15:8], go to LO.
- LO:
  - byte_ready = 1.
  - On byte_valid: latch byte_data into hold[7:0], go to WRITE.
- WRITE:
  - byte_ready = 0.
  - ram_in = hold, ram_address = addr counter, ram_load = 1.
  - The RAM captures the word on the next clock edge.
  - On that edge:
    - checksum += hold (discard carry);
    - word_count += 1;
    - address counter += 1.
  - If word_count before increment == WORDS-1: go to DONE and set done. Otherwise go to HI.
- In HI/LO/WRITE:
  - ram_* outputs are driven by the loader.
  - cpu_load is ignored; CPU writes during a load are dropped, not queued.
- abort in HI/LO/WRITE:
  - go to IDLE;
  - done stays 0;
  - word_count and checksum hold their values.
  - A word already in WRITE on the abort cycle is not written: ram_load is forced to 0 that cycle.
- start while busy is ignored. abort in IDLE/DONE is ignored.
- Address counter is 12 bits. With WORDS = 4096, the final write is at 0xFFF and the counter wraps to 0; no write occurs after the wrap.
- busy = (state is HI, LO or WRITE).

## Timing
- Reset (async, rst_n low) sets:
  - state = IDLE;
  - hold = 0, address counter = 0, word_count = 0, checksum = 0;
  - busy = 0, done = 0, byte_ready = 0.
- ram_* follow the cpu_* passthrough immediately after reset.
- Reset mid-load takes effect immediately. No further ram_load is issued; words already written remain in the RAM.
- A byte is transferred on the rising edge where byte_valid & byte_ready = 1. byte_data must be stable in that cycle.
- Minimum 3 cycles per word: HI, LO, WRITE. A full 4096-word load takes ≥ 12288 cycles after start.
- Fixed latencies:
  - start edge → byte_ready high the next cycle;
  - low-byte accept edge → ram_load high for exactly one cycle;
  - done rises on the edge that commits the final write.
- Stalls: byte_valid low holds the state indefinitely, with no timeout.
- Outputs busy, done, byte_ready, word_count and checksum are registered or decoded from registered state only. ram_* are combinational muxes.

## Test plan
- WORDS=3, bytes 12 34 AB CD 00 01 with no gaps:
  - RAM[0]=0x1234, RAM[1]=0xABCD, RAM[2]=0x0001;
  - word_count=3, checksum=0xBE02;
  - done=1 at cycle 9 after start; busy=0 afterward.
- byte_valid deasserted for 5 cycles between the high and low bytes:
  - state holds LO and no ram_load pulse occurs;
  - the word is written once when the low byte arrives; total latency is +5 cycles.
- abort asserted in the WRITE cycle of word 2 (WORDS=4):
  - no write to address 1;
  - state=IDLE, done=0, word_count=1.
- cpu_load=1, cpu_address=0x123, cpu_in=0x5555:
  - in IDLE, RAM[0x123]=0x5555;
  - the same request issued during HI leaves RAM[0x123] unchanged.
- rst_n pulsed low while in LO:
  - all outputs go to reset values immediately;
  - a subsequent start reloads from address 0.
- WORDS=4096, all-zero stream:
  - the final write lands at 0xFFF;
  - word_count=4096, done=1, address counter=0, no extra ram_load;
  - start asserted during the load has no effect.
